// File: rtl/fetch_pkg.sv
// Shared types and PC helpers for the instruction fetch front end.
package fetch_pkg;

    localparam int unsigned ADDR_W  = 64;
    localparam int unsigned INSTR_W = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        FLUSH = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [ADDR_W-1:0]  addr;
    } fetch_entry_t;

    // 32-bit addressing keeps the upper half of every PC at zero
    function automatic logic [ADDR_W-1:0] pc_mask(input logic [ADDR_W-1:0] pc, input logic mode32);
        return mode32 ? {32'h0, pc[31:0]} : pc;
    endfunction

    function automatic logic [ADDR_W-1:0] pc_next(input logic [ADDR_W-1:0] pc, input logic mode32);
        return pc_mask(pc + ADDR_W'(4), mode32);
    endfunction

endpackage

// File: rtl/fetch_if.sv
// Fetch bus bundle: instruction-memory request/response plus the decode-side stream.
interface fetch_if;

    logic                         mem_req_valid;
    logic                         mem_req_ready;
    logic [fetch_pkg::ADDR_W-1:0] mem_req_addr;
    logic                         mem_rsp_valid;
    logic [fetch_pkg::INSTR_W-1:0] mem_rsp_data;
    logic                         instr_valid;
    logic                         instr_ready;
    logic [fetch_pkg::INSTR_W-1:0] instr;
    logic [fetch_pkg::ADDR_W-1:0] instr_addr;

    modport master (
        output mem_req_valid, mem_req_addr, instr_valid, instr, instr_addr,
        input  mem_req_ready, mem_rsp_valid, mem_rsp_data, instr_ready
    );

    modport slave (
        input  mem_req_valid, mem_req_addr, instr_valid, instr, instr_addr,
        output mem_req_ready, mem_rsp_valid, mem_rsp_data, instr_ready
    );

endinterface

// File: rtl/fetch_fifo.sv
// Synchronous instruction buffer of fetch entries with clear, count, full and empty.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clear,
    input  logic                       push,
    input  fetch_entry_t               push_data,
    input  logic                       pop,
    output fetch_entry_t               head,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    fetch_entry_t     mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W-1:0] wr_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign head    = mem_q[rd_ptr_q];
    assign do_pop  = pop && !empty;
    // a full buffer still accepts a word when the head leaves in the same cycle
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else if (clear) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (do_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
            count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !clear) mem_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch front end: PC sequencing, credit-limited memory requests, in-order buffering, redirect flush.
// Optional FETCH_PERF_CNT_EN enables the discarded-word counter on o_flush_cnt.
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_ADDR = 64'h0,
    parameter int unsigned       FIFO_DEPTH = 4
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_en,
    input  logic              i_32b_mode,
    input  logic              i_redirect_valid,
    input  logic [ADDR_W-1:0] i_redirect_addr,
    fetch_if.master           bus,
    output logic [31:0]       o_flush_cnt
);

    localparam int unsigned CNT_W    = $clog2(FIFO_DEPTH + 1);
    localparam logic [1:0]  ST_IDLE  = 2'(IDLE);
    localparam logic [1:0]  ST_FETCH = 2'(FETCH);
    localparam logic [1:0]  ST_FLUSH = 2'(FLUSH);

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0] rsp_pc_q, rsp_pc_d;
    logic [CNT_W-1:0]  outstanding_q, outstanding_d;
    logic [CNT_W-1:0]  drop_q, drop_d;
    logic [CNT_W-1:0]  fifo_count;
    logic              fifo_full;
    logic              fifo_empty;
    fetch_entry_t      head;
    fetch_entry_t      push_entry;
    logic              req_valid_c;
    logic              req_fire, rsp_fire, pop_fire;
    logic              push, drop_now;
    logic [CNT_W:0]    inflight;
    logic [ADDR_W-1:0] redirect_pc;

    assign req_valid_c = (state_q == ST_FETCH) &&
                         (({1'b0, fifo_count} + {1'b0, outstanding_q}) < (CNT_W+1)'(FIFO_DEPTH));
    assign req_fire    = req_valid_c && bus.mem_req_ready;
    assign rsp_fire    = bus.mem_rsp_valid;
    assign pop_fire    = !fifo_empty && bus.instr_ready;
    // words in flight after this edge; every one of them is wrong-path when a redirect lands
    assign inflight    = {1'b0, outstanding_q} + (CNT_W+1)'(req_fire) - (CNT_W+1)'(rsp_fire);
    assign drop_now    = rsp_fire && (drop_q != '0) && !i_redirect_valid;
    assign push        = rsp_fire && (drop_q == '0) && !i_redirect_valid;
    assign redirect_pc = pc_mask(i_redirect_addr & ~ADDR_W'(3), i_32b_mode);
    assign push_entry  = '{instr: bus.mem_rsp_data, addr: rsp_pc_q};

    // Next-state and datapath update
    always_comb begin
        state_d       = state_q;
        fetch_pc_d    = fetch_pc_q;
        rsp_pc_d      = rsp_pc_q;
        drop_d        = drop_q;
        outstanding_d = CNT_W'(inflight);
        if (req_fire) fetch_pc_d = pc_next(fetch_pc_q, i_32b_mode);
        if (push)     rsp_pc_d   = pc_next(rsp_pc_q, i_32b_mode);
        if (drop_now) drop_d     = drop_q - CNT_W'(1);
        case (state_q)
            ST_IDLE:  if (i_en) state_d = ST_FETCH;
            ST_FETCH: if (!i_en) state_d = ST_IDLE;
            ST_FLUSH: if (drop_d == '0) state_d = i_en ? ST_FETCH : ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
        if (i_redirect_valid) begin
            fetch_pc_d = redirect_pc;
            rsp_pc_d   = redirect_pc;
            drop_d     = CNT_W'(inflight);
            state_d    = (inflight != '0) ? ST_FLUSH : (i_en ? ST_FETCH : ST_IDLE);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q       <= ST_IDLE;
            fetch_pc_q    <= RESET_ADDR;
            rsp_pc_q      <= RESET_ADDR;
            outstanding_q <= '0;
            drop_q        <= '0;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            rsp_pc_q      <= rsp_pc_d;
            outstanding_q <= outstanding_d;
            drop_q        <= drop_d;
        end
    end

    fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (i_clk),
        .rst_n     (i_rst),
        .clear     (i_redirect_valid),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop_fire),
        .head      (head),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign bus.mem_req_valid = req_valid_c;
    assign bus.mem_req_addr  = fetch_pc_q;
    assign bus.instr_valid   = !fifo_empty;
    assign bus.instr         = fifo_empty ? '0 : head.instr;
    assign bus.instr_addr    = fifo_empty ? '0 : head.addr;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0]    flush_cnt_q;
    logic [CNT_W:0] discard_c;
    logic [32:0]    flush_sum_c;

    // Buffered words cleared by a redirect plus responses dropped on the floor
    always_comb begin
        discard_c = '0;
        if (i_redirect_valid)
            discard_c = (CNT_W+1)'(fifo_count) - (CNT_W+1)'(pop_fire) + (CNT_W+1)'(rsp_fire);
        else if (drop_now)
            discard_c = (CNT_W+1)'(1);
        flush_sum_c = {1'b0, flush_cnt_q} + 33'(discard_c);
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) flush_cnt_q <= '0;
        else        flush_cnt_q <= flush_sum_c[32] ? 32'hFFFF_FFFF : flush_sum_c[31:0];
    end

    assign o_flush_cnt = flush_cnt_q;
`else
    assign o_flush_cnt = '0;
`endif

    a_rsp_underflow: assert property (@(posedge i_clk) disable iff (!i_rst)
        !(rsp_fire && (outstanding_q == '0)));
    a_push_full: assert property (@(posedge i_clk) disable iff (!i_rst)
        !(push && fifo_full && !pop_fire));

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Randomized bench for instr_fetch_unit against an architectural-stream reference model.
module tb_instr_fetch_unit;

    localparam logic [63:0] RST_PC = 64'h100;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        mode_pin;
    logic        redir_v;
    logic [63:0] redir_a;
    logic [31:0] flush_cnt;

    fetch_if bus ();

    instr_fetch_unit #(.RESET_ADDR(RST_PC), .FIFO_DEPTH(4)) dut (
        .i_clk            (clk),
        .i_rst            (rst_n),
        .i_en             (en),
        .i_32b_mode       (mode_pin),
        .i_redirect_valid (redir_v),
        .i_redirect_addr  (redir_a),
        .bus              (bus),
        .o_flush_cnt      (flush_cnt)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [63:0] exp_pc, exp_req, last_pop_addr;
    bit          mode32, expect_gap;
    logic [63:0] addr_q [$];
    longint      due_q [$];
    logic [63:0] req_hist [$];
    longint      cyc;
    int          n_req, n_rsp, n_pop, n_disc;
    int          lat_min = 1;
    int          lat_max = 3;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] word_of(input logic [63:0] a);
        return (a[31:0] * 32'h9E37_79B9) ^ a[63:32];
    endfunction

    function automatic logic [63:0] seq_next(input logic [63:0] pc);
        logic [63:0] n;
        n = pc + 64'd4;
        return mode32 ? (n & 64'h0000_0000_FFFF_FFFF) : n;
    endfunction

    function automatic logic [63:0] align(input logic [63:0] t);
        return mode32 ? (t & 64'h0000_0000_FFFF_FFFC) : (t & ~64'h3);
    endfunction

    task automatic model_reset();
        addr_q.delete();
        due_q.delete();
        exp_pc = RST_PC;
        exp_req = RST_PC;
        n_req = 0; n_rsp = 0; n_pop = 0; n_disc = 0;
        expect_gap = 0;
        mode32 = 0;
    endtask

    // One clock: drive inputs at negedge, score what the coming posedge transfers
    task automatic step(input bit e, input bit mrdy, input bit drdy, input bit rd, input logic [63:0] tgt);
        bit req_f, pop_f, rsp_f;
        if (expect_gap) begin
            check("gap_after_redirect", 64'(bus.instr_valid), 64'd0);
            expect_gap = 0;
        end
        rsp_f = (due_q.size() > 0) && (due_q[0] <= cyc);
        en = e; bus.mem_req_ready = mrdy; bus.instr_ready = drdy;
        redir_v = rd; redir_a = tgt;
        bus.mem_rsp_valid = rsp_f;
        if (rsp_f) bus.mem_rsp_data = word_of(addr_q[0]);
        else       bus.mem_rsp_data = 32'($urandom);
        req_f = bus.mem_req_valid && mrdy;
        pop_f = bus.instr_valid && drdy;
        if (pop_f) begin
            check("instr_addr", bus.instr_addr, exp_pc);
            check("instr_word", 64'(bus.instr), 64'(word_of(exp_pc)));
            last_pop_addr = bus.instr_addr;
            exp_pc = seq_next(exp_pc);
            n_pop++;
        end
        if (rsp_f) begin
            void'(addr_q.pop_front());
            void'(due_q.pop_front());
            n_rsp++;
        end
        if (req_f) begin
            check("req_addr", bus.mem_req_addr, exp_req);
            addr_q.push_back(bus.mem_req_addr);
            due_q.push_back(cyc + longint'(lat_min) + longint'($urandom_range(lat_max - lat_min)));
            req_hist.push_back(bus.mem_req_addr);
            exp_req = seq_next(exp_req);
            n_req++;
        end
        if (rd) begin
            exp_pc = align(tgt);
            exp_req = align(tgt);
            n_disc = n_req - n_pop;
            expect_gap = 1;
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic drain();
        for (int i = 0; i < 16; i++) step(0, 1, 1, 0, 64'h0);
    endtask

    task automatic check_flush(input string tag);
`ifdef FETCH_PERF_CNT_EN
        check(tag, 64'(flush_cnt), 64'(n_disc));
`else
        check(tag, 64'(flush_cnt), 64'd0);
`endif
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_valid"}, 64'(bus.mem_req_valid), 64'd0);
        check({tag, "_req_addr"}, bus.mem_req_addr, RST_PC);
        check({tag, "_instr_valid"}, 64'(bus.instr_valid), 64'd0);
        check({tag, "_instr"}, 64'(bus.instr), 64'd0);
        check({tag, "_instr_addr"}, bus.instr_addr, 64'd0);
        check({tag, "_flush_cnt"}, 64'(flush_cnt), 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int base, base_pop, guard;
        bit found;
        rst_n = 0; en = 0; mode_pin = 0; redir_v = 0; redir_a = '0;
        bus.mem_req_ready = 0; bus.mem_rsp_valid = 0; bus.mem_rsp_data = '0; bus.instr_ready = 0;
        cyc = 0;
        model_reset();
        repeat (3) @(negedge clk);
        check_reset_outputs("rst");
        rst_n = 1;

        // Sequential fetch with single-cycle memory
        lat_min = 1; lat_max = 1;
        guard = 0;
        while (n_pop < 3 && guard < 20) begin step(1, 1, 1, 0, 64'h0); guard++; end
        check("t1_three_pops", 64'(n_pop >= 3), 64'd1);
        check("t1_first_req", req_hist[0], RST_PC);

        // Decode stall: credit limit caps fires at buffer depth
        drain();
        base = n_req;
        for (int i = 0; i < 20; i++) step(1, 1, 0, 0, 64'h0);
        check("t2_fires", 64'(n_req - base), 64'd4);
        check("t2_req_stalled", 64'(bus.mem_req_valid), 64'd0);
        base_pop = n_pop;
        for (int i = 0; i < 12; i++) step(1, 1, 1, 0, 64'h0);
        check("t2_pops", 64'(n_pop - base_pop >= 4), 64'd1);
        check("t2_resumed", 64'(n_req - base > 4), 64'd1);

        // Redirect with two requests outstanding
        drain();
        lat_min = 3; lat_max = 3;
        guard = 0;
        while ((n_req - n_rsp) != 2 && guard < 20) begin step(1, 1, 0, 0, 64'h0); guard++; end
        check("t3_setup", 64'(n_req - n_rsp), 64'd2);
        lat_min = 1; lat_max = 3;
        base_pop = n_pop;
        step(1, 1, 1, 1, 64'h2003);
        guard = 0;
        while (n_pop == base_pop && guard < 30) begin step(1, 1, 1, 0, 64'h0); guard++; end
        check("t3_first_addr", last_pop_addr, 64'h2000);
        drain();
        check_flush("t3_flush");

        // 32-bit mode wraps at 2^32
        mode32 = 1; mode_pin = 1;
        base = req_hist.size();
        step(1, 1, 1, 1, 64'hFFFF_FFFC);
        guard = 0;
        while (req_hist.size() < base + 3 && guard < 20) begin step(1, 1, 1, 0, 64'h0); guard++; end
        if (req_hist.size() >= base + 3) begin
            check("t4_req0", req_hist[base], 64'hFFFF_FFFC);
            check("t4_req1", req_hist[base + 1], 64'h0);
            check("t4_req2", req_hist[base + 2], 64'h4);
        end else begin
            check("t4_reqs_seen", 64'(req_hist.size()), 64'(base + 3));
        end
        drain();
        mode32 = 0; mode_pin = 0;
        step(1, 1, 1, 1, 64'h3000);
        for (int i = 0; i < 8; i++) step(1, 1, 1, 0, 64'h0);
        drain();
        check_flush("t4_flush");

        // Redirect coinciding with a request fire and a response
        lat_min = 1; lat_max = 2;
        found = 0;
        for (int i = 0; i < 50 && !found; i++) begin
            if (bus.mem_req_valid && due_q.size() > 0 && due_q[0] <= cyc) found = 1;
            else step(1, 1, 1, 0, 64'h0);
        end
        check("t5_setup", 64'(found), 64'd1);
        step(1, 1, 1, 1, 64'h4000);
        for (int i = 0; i < 12; i++) step(1, 1, 1, 0, 64'h0);
        check("t5_target_reached", 64'(last_pop_addr >= 64'h4000), 64'd1);
        drain();
        check_flush("t5_flush");

        // Random traffic with random redirects and stalls
        lat_min = 1; lat_max = 3;
        base_pop = n_pop;
        for (int i = 0; i < 1500; i++) begin
            step(($urandom % 8) != 0, ($urandom % 4) != 0, ($urandom % 3) != 0,
                 ($urandom % 20) == 0, {32'($urandom), 32'($urandom)});
        end
        drain();
        check_flush("rand_flush");
        check("rand_pops", 64'(n_pop - base_pop > 300), 64'd1);

        // Asynchronous reset mid-burst
        for (int i = 0; i < 10; i++) step(1, 1, 1, 0, 64'h0);
        @(posedge clk);
        #2;
        rst_n = 0;
        #1;
        check_reset_outputs("t6");
        en = 0; redir_v = 0; mode_pin = 0;
        bus.mem_rsp_valid = 0; bus.instr_ready = 0; bus.mem_req_ready = 0;
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1;
        base = req_hist.size();
        guard = 0;
        while (n_pop < 3 && guard < 30) begin step(1, 1, 1, 0, 64'h0); guard++; end
        check("t6_restart", 64'(n_pop >= 3), 64'd1);
        if (req_hist.size() > base) check("t6_first_req", req_hist[base], RST_PC);
        else check("t6_req_seen", 64'(req_hist.size()), 64'(base + 1));
        drain();
        check_flush("t6_flush");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
